// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential 64-bit multiply / radix-2 restoring divide unit
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iterative path.
module muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [3:0]  op_in,
    input  logic [63:0] a_in,
    input  logic [63:0] b_in,
    output logic        ready_out,
    input  logic        flush,
    output logic        valid_out,
    output logic [63:0] result,
    input  logic        ready_in
);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_op;
    logic [63:0] r_a, r_b, r_rem, r_quo, r_div, r_result;
    logic [6:0]  r_cnt;
    logic        r_dz, r_ovf;

    logic        w_accept, w_is_w, w_signed, w_dz, w_ovf, w_early;
    logic [63:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_prod;
    logic [64:0] w_shift, w_trial;
    logic [63:0] w_q, w_r, w_fix_val;

    function automatic logic [63:0] f_wrap(input logic is_w, input logic [63:0] v);
        return is_w ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    // Only meaningful when the operands are a divide-by-zero or signed-overflow pair.
    function automatic logic [63:0] f_special(input logic is_rem, input logic dz,
                                              input logic [63:0] a);
        if (dz)
            return is_rem ? a : '1;
        return is_rem ? 64'd0 : a;
    endfunction

    assign w_accept = valid_in & ready_out & ~flush;
    assign w_is_w   = op_in[3];
    assign w_signed = ~op_in[0];
    assign w_a_ext  = !w_is_w ? a_in :
                      w_signed ? {{32{a_in[31]}}, a_in[31:0]} : {32'd0, a_in[31:0]};
    assign w_b_ext  = !w_is_w ? b_in :
                      w_signed ? {{32{b_in[31]}}, b_in[31:0]} : {32'd0, b_in[31:0]};
    assign w_a_mag  = (w_signed & w_a_ext[63]) ? -w_a_ext : w_a_ext;
    assign w_b_mag  = (w_signed & w_b_ext[63]) ? -w_b_ext : w_b_ext;
    assign w_dz     = (w_b_ext == 64'd0);
    assign w_ovf    = w_signed & (w_b_ext == '1) &
                      (w_a_ext == (w_is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early = op_in[2] & (w_dz | w_ovf);
`else
    assign w_early = 1'b0;
`endif

    assign w_prod  = r_a * r_b;
    assign w_shift = {r_rem, r_quo[63]};
    assign w_trial = w_shift - {1'b0, r_div};

    assign w_q       = (~r_op[0] & (r_a[63] ^ r_b[63])) ? -r_quo : r_quo;
    assign w_r       = (~r_op[0] & r_a[63]) ? -r_rem : r_rem;
    assign w_fix_val = f_wrap(r_op[3], (r_dz | r_ovf) ? f_special(r_op[1], r_dz, r_a)
                                                       : (r_op[1] ? w_r : w_q));

    assign ready_out = (r_state == IDLE);
    assign valid_out = (r_state == DONE);
    assign result    = r_result;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = w_early ? DONE : (op_in[2] ? DIV : MUL);
            MUL:  w_next = DONE;
            DIV:  if (r_cnt == 7'd1) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: if (ready_in) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (flush)
            w_next = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_op  <= op_in;
                    r_a   <= w_a_ext;
                    r_b   <= w_b_ext;
                    r_dz  <= w_dz;
                    r_ovf <= w_ovf;
                    r_rem <= '0;
                    r_div <= w_b_mag;
                    // W dividends start in the upper half so 32 shifts leave the quotient low.
                    r_quo <= w_is_w ? {w_a_mag[31:0], 32'd0} : w_a_mag;
                    r_cnt <= w_is_w ? 7'd32 : 7'd64;
                    if (w_early)
                        r_result <= f_wrap(w_is_w, f_special(op_in[1], w_dz, w_a_ext));
                end
                MUL: if (!flush) r_result <= f_wrap(r_op[3], w_prod);
                DIV: begin
                    r_rem <= w_trial[64] ? w_shift[63:0] : w_trial[63:0];
                    r_quo <= {r_quo[62:0], ~w_trial[64]};
                    r_cnt <= r_cnt - 7'd1;
                end
                FIX: if (!flush) r_result <= w_fix_val;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [3:0]  op_in;
    logic [63:0] a_in, b_in;
    logic        ready_out;
    logic        flush;
    logic        valid_out;
    logic [63:0] result;
    logic        ready_in;

    int n_total = 0;
    int n_bad   = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_SP  = 1;
    localparam int LAT_SPW = 1;
`else
    localparam int LAT_SP  = 66;
    localparam int LAT_SPW = 34;
`endif

    muldiv_seq dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .op_in     (op_in),
        .a_in      (a_in),
        .b_in      (b_in),
        .ready_out (ready_out),
        .flush     (flush),
        .valid_out (valid_out),
        .result    (result),
        .ready_in  (ready_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues one request and returns after the first cycle with valid_out high.
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         output int lat);
        @(negedge clk);
        valid_in = 1'b1;
        op_in    = op;
        a_in     = a;
        b_in     = b;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        lat = 1;
        while (!valid_out && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input int exp_lat, input logic [63:0] exp_res);
        int lat;
        issue(op, a, b, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, result, exp_res);
        @(posedge clk);
        #1;
        chk({tag, "_rdy"}, {63'd0, ready_out}, 64'd1);
    endtask

    initial begin
        int lat;
        int seen;
        reset    = 1'b0;
        valid_in = 1'b0;
        op_in    = '0;
        a_in     = '0;
        b_in     = '0;
        flush    = 1'b0;
        ready_in = 1'b1;
        #1;
        chk("rst_valid", {63'd0, valid_out}, 64'd0);
        chk("rst_result", result, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", {63'd0, ready_out}, 64'd1);

        run_op("mul",    4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mulw",   4'b1000, 64'h7FFF_FFFF, 64'd2, 2, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mul_x2", 4'b0010, 64'd3, 64'd5, 2, 64'd15);
        run_op("div",    4'b0100, -64'sd7, 64'd2, 66, -64'sd3);
        run_op("rem",    4'b0110, -64'sd7, 64'd2, 66, -64'sd1);
        run_op("remu",   4'b0111, 64'd100, 64'd7, 66, 64'd2);
        run_op("divuw",  4'b1101, 64'h1_0000_0010, 64'd4, 34, 64'd4);
        run_op("divw",   4'b1100, 64'd100, 64'd7, 34, 64'd14);
        run_op("remw",   4'b1110, 64'h0000_0000_FFFF_FFF9, 64'd2, 34, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("divu_z", 4'b0101, 64'd5, 64'd0, LAT_SP, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("rem_z",  4'b0110, 64'd5, 64'd0, LAT_SP, 64'd5);
        run_op("div_zn", 4'b0100, -64'sd5, 64'd0, LAT_SP, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("div_ov", 4'b0100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, LAT_SP,
               64'h8000_0000_0000_0000);
        run_op("divw_ov", 4'b1100, 64'h8000_0000, 64'hFFFF_FFFF, LAT_SPW, 64'hFFFF_FFFF_8000_0000);
        run_op("remw_z", 4'b1111, 64'h8000_0001, 64'd0, LAT_SPW, 64'hFFFF_FFFF_8000_0001);

        ready_in = 1'b0;
        issue(4'b0000, 64'd6, 64'd7, lat);
        chk("bp_lat", 64'(lat), 64'd2);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", {63'd0, valid_out}, 64'd1);
            chk("bp_result", result, 64'd42);
            chk("bp_ready", {63'd0, ready_out}, 64'd0);
        end
        @(negedge clk);
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rel_ready", {63'd0, ready_out}, 64'd1);
        chk("bp_rel_valid", {63'd0, valid_out}, 64'd0);

        @(negedge clk);
        valid_in = 1'b1;
        op_in    = 4'b0100;
        a_in     = 64'd1000;
        b_in     = 64'd3;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fl_ready", {63'd0, ready_out}, 64'd1);
        chk("fl_valid", {63'd0, valid_out}, 64'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (valid_out) seen = 1;
        end
        chk("fl_no_result", 64'(seen), 64'd0);
        run_op("fl_mul", 4'b0000, 64'd3, 64'd4, 2, 64'd12);

        @(negedge clk);
        valid_in = 1'b1;
        op_in    = 4'b0000;
        a_in     = 64'd9;
        b_in     = 64'd9;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rm_valid", {63'd0, valid_out}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (valid_out) seen = 1;
        end
        chk("rm_no_result", 64'(seen), 64'd0);
        chk("rm_ready", {63'd0, ready_out}, 64'd1);

        ready_in = 1'b0;
        issue(4'b0000, 64'd5, 64'd5, lat);
        chk("rd_lat", 64'(lat), 64'd2);
        chk("rd_pre_result", result, 64'd25);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rd_valid", {63'd0, valid_out}, 64'd0);
        chk("rd_result", result, 64'd0);
        @(negedge clk);
        reset    = 1'b1;
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        chk("rd_ready", {63'd0, ready_out}, 64'd1);
        chk("rd_valid2", {63'd0, valid_out}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have ports: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: valid_in  input  1  request valid; op_in  input  4  mul/div op code; a_in, b_in  input  64 each  operand A, operand B.
REQ-004 SHALL have ports: ready_out  output  1  unit can accept; flush  input  1  abort the in-flight op.
REQ-005 SHALL have ports: valid_out  output  1  result valid; result  output  64  result value; ready_in  input  1  downstream accepts result.
REQ-006 SHALL decode op_in as: bit3 = W (32-bit) form, bit2 = divide class, bit1 = remainder, bit0 = unsigned; 0000 mul, 0100 div, 0101 divu, 0110 rem, 0111 remu, 1000 mulw, 1100 divw, 1101 divuw, 1110 remw, 1111 remuw; other codes with bit2=0 SHALL execute as mul/mulw.

Function
REQ-007 SHALL implement states IDLE, MUL, DIV, FIX, DONE; ready_out = (state==IDLE).
REQ-008 SHALL accept a request on a cycle with valid_in & ready_out & !flush, latching op, a_in and b_in.
REQ-009 W forms: operands SHALL be taken from bits [31:0], sign-extended for signed ops and zero-extended for unsigned ops; the result SHALL be bits [31:0] of the computed value, sign-extended to 64 bits.
REQ-010 Mul path: IDLE->MUL->DONE; result = low 64 bits of A*B; valid_out SHALL first assert 2 cycles after the accept edge.
REQ-011 Div path: IDLE->DIV; radix-2 restoring division on operand magnitudes, one quotient bit per cycle, iteration counter 64 (W: 32); DIV->FIX after the last iteration; FIX->DONE.
REQ-012 Div latency: valid_out SHALL first assert 66 cycles (W: 34) after the accept edge.
REQ-013 FIX SHALL apply signs: quotient negative iff operand signs differ (signed ops); remainder takes the sign of the dividend.
REQ-014 Divide by zero: quotient SHALL be all ones (W: 0xFFFFFFFF sign-extended); remainder SHALL equal the dividend.
REQ-015 Signed overflow (most-negative / -1, at 64 or 32 bits): quotient SHALL equal the dividend; remainder SHALL be 0.
REQ-016 DONE SHALL hold valid_out=1 and result stable until ready_in=1; on valid_out & ready_in -> IDLE; no new accept in the same cycle.
REQ-017 flush SHALL have highest priority: any state -> IDLE at the next edge, the result discarded, and valid_out=0 from that edge.
REQ-018 ready_in SHALL be ignored outside DONE; valid_in SHALL be ignored outside IDLE.

Reset
REQ-019 reset=0 SHALL immediately force state=IDLE, valid_out=0, result=0, counter=0, and ready_out=1 once reset releases.
REQ-020 Reset asserted mid-operation SHALL discard the operation without producing a result.

Configuration
REQ-021 Macro MULDIV_EARLY_OUT_EN defined: divide-by-zero and signed-overflow requests SHALL go IDLE->DONE directly, with valid_out 1 cycle after accept.
REQ-022 MULDIV_EARLY_OUT_EN undefined: these cases SHALL take the full div latency (REQ-012) and still produce the REQ-014/015 values; mul latency SHALL be unaffected in both builds.

Verification
REQ-023 mul a=0xFFFFFFFFFFFFFFFF b=2, ready_in=1 -> valid_out at cycle 2, result=0xFFFFFFFFFFFFFFFE; mulw a=0x7FFFFFFF b=2 -> 0xFFFFFFFFFFFFFFFE.
REQ-024 div a=-7 b=2 -> result=-3 at cycle 66; rem same operands -> -1; divuw a=0x1_00000010 b=4 -> 4 at cycle 34.
REQ-025 divu a=5 b=0 -> 0xFFFFFFFFFFFFFFFF; rem a=5 b=0 -> 5; div a=0x8000000000000000 b=-1 -> 0x8000000000000000; latency 1 cycle with macro, 66 cycles without.
REQ-026 Backpressure: ready_in=0 for 10 cycles in DONE -> valid_out and result stable, ready_out=0; ready_in=1 -> IDLE next cycle, ready_out=1.
REQ-027 flush at DIV iteration 20 -> IDLE next cycle, no valid_out; a following mul 3*4 -> 12 at cycle 2.
REQ-028 reset=0 during MUL and during DONE -> valid_out=0 immediately, ready_out=1 after release.
